// File: rtl/axi4_apb_bridge.sv
// axi4_apb_bridge: AXI4 slave to APB master bridge.
// One AXI burst is in flight at a time. Each beat becomes one APB SETUP/ACCESS pair.
// Read and write address channels are arbitrated round-robin while the bridge is IDLE.
module axi4_apb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  // AXI read address
  output logic              in_arready,
  input  logic              in_arvalid,
  input  logic [ID_W-1:0]   in_arid,
  input  logic [ADDR_W-1:0] in_araddr,
  input  logic [7:0]        in_arlen,
  input  logic [2:0]        in_arsize,
  input  logic [1:0]        in_arburst,
  // AXI read data
  input  logic              in_rready,
  output logic              in_rvalid,
  output logic [ID_W-1:0]   in_rid,
  output logic [DATA_W-1:0] in_rdata,
  output logic [1:0]        in_rresp,
  output logic              in_rlast,
  // AXI write address
  output logic              in_awready,
  input  logic              in_awvalid,
  input  logic [ID_W-1:0]   in_awid,
  input  logic [ADDR_W-1:0] in_awaddr,
  input  logic [7:0]        in_awlen,
  input  logic [2:0]        in_awsize,
  input  logic [1:0]        in_awburst,
  // AXI write data
  output logic              in_wready,
  input  logic              in_wvalid,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [STRB_W-1:0] in_wstrb,
  input  logic              in_wlast,
  // AXI write response
  input  logic              in_bready,
  output logic              in_bvalid,
  output logic [ID_W-1:0]   in_bid,
  output logic [1:0]        in_bresp,
  // APB master
  output logic              out_psel,
  output logic              out_penable,
  output logic              out_pwrite,
  output logic [ADDR_W-1:0] out_paddr,
  output logic [DATA_W-1:0] out_pwdata,
  output logic [STRB_W-1:0] out_pstrb,
  input  logic              out_pready,
  input  logic [DATA_W-1:0] out_prdata,
  input  logic              out_pslverr
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] R_SETUP  = 3'd1;
  localparam logic [2:0] R_ACCESS = 3'd2;
  localparam logic [2:0] R_RESP   = 3'd3;
  localparam logic [2:0] W_DATA   = 3'd4;
  localparam logic [2:0] W_SETUP  = 3'd5;
  localparam logic [2:0] W_ACCESS = 3'd6;
  localparam logic [2:0] B_RESP   = 3'd7;

  // last_grant encoding: the reset value (write) lets a read win the first tie.
  localparam logic LG_WRITE = 1'b0;
  localparam logic LG_READ  = 1'b1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        beat_q, beat_d;
  logic              err_q, err_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic              grant_r, grant_w;
  logic              is_last;
  logic [ADDR_W-1:0] addr_adv;

  // Burst termination is driven purely by the beat counter, so wlast carries no information.
  logic unused_wlast;
  assign unused_wlast = in_wlast;

  // Address of the next beat for FIXED / INCR / WRAP; the reserved encoding behaves as INCR.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] boundary;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] inc;
    bytes    = ADDR_W'(1) << size;
    boundary = (ADDR_W'(len) + ADDR_W'(1)) * bytes;
    mask     = boundary - ADDR_W'(1);
    inc      = a + bytes;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  // On a tie the channel that did not win last time is granted.
  assign grant_r  = in_arvalid & (~in_awvalid | (last_grant_q == LG_WRITE));
  assign grant_w  = in_awvalid & ~grant_r;
  assign is_last  = (beat_q == len_q);
  assign addr_adv = next_addr(addr_q, len_q, size_q, burst_q);

  // AXI side outputs; readies are forced low while reset is asserted.
  assign in_arready = (state_q == IDLE) & grant_r & ~reset;
  assign in_awready = (state_q == IDLE) & grant_w & ~reset;
  assign in_wready  = (state_q == W_DATA) & ~reset;
  assign in_rvalid  = (state_q == R_RESP);
  assign in_rid     = id_q;
  assign in_rdata   = rdata_q;
  assign in_rresp   = rresp_q;
  assign in_rlast   = is_last;
  assign in_bvalid  = (state_q == B_RESP);
  assign in_bid     = id_q;
  assign in_bresp   = err_q ? 2'b10 : 2'b00;

  // APB side outputs are decoded from state, so an async reset drops psel/penable at once.
  assign out_psel    = (state_q == R_SETUP) | (state_q == R_ACCESS) |
                       (state_q == W_SETUP) | (state_q == W_ACCESS);
  assign out_penable = (state_q == R_ACCESS) | (state_q == W_ACCESS);
  assign out_pwrite  = (state_q == W_SETUP) | (state_q == W_ACCESS);
  assign out_paddr   = addr_q;
  assign out_pwdata  = wdata_q;
  assign out_pstrb   = out_pwrite ? wstrb_q : '0;

  // Next-state and datapath update for the beat-by-beat transfer sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    id_d         = id_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    case (state_q)
      IDLE: begin
        if (grant_r) begin
          id_d         = in_arid;
          addr_d       = in_araddr;
          len_d        = in_arlen;
          size_d       = in_arsize;
          burst_d      = in_arburst;
          beat_d       = 8'd0;
          err_d        = 1'b0;
          last_grant_d = LG_READ;
          state_d      = R_SETUP;
        end else if (grant_w) begin
          id_d         = in_awid;
          addr_d       = in_awaddr;
          len_d        = in_awlen;
          size_d       = in_awsize;
          burst_d      = in_awburst;
          beat_d       = 8'd0;
          err_d        = 1'b0;
          last_grant_d = LG_WRITE;
          state_d      = W_DATA;
        end
      end
      R_SETUP: state_d = R_ACCESS;
      R_ACCESS: begin
        if (out_pready) begin
          rdata_d = out_prdata;
          rresp_d = out_pslverr ? 2'b10 : 2'b00;
          state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (in_rready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_adv;
            beat_d  = beat_q + 8'd1;
            state_d = R_SETUP;
          end
        end
      end
      W_DATA: begin
        if (in_wvalid) begin
          wdata_d = in_wdata;
          wstrb_d = in_wstrb;
          state_d = W_SETUP;
        end
      end
      W_SETUP: state_d = W_ACCESS;
      W_ACCESS: begin
        if (out_pready) begin
          err_d = err_q | out_pslverr;
          if (is_last) begin
            state_d = B_RESP;
          end else begin
            addr_d  = addr_adv;
            beat_d  = beat_q + 8'd1;
            state_d = W_DATA;
          end
        end
      end
      B_RESP: begin
        if (in_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset abandons any transfer and its pending response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      id_q         <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      last_grant_q <= LG_WRITE;
      rdata_q      <= '0;
      rresp_q      <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

endmodule
